fir_sample_reader: RTL and testbench

Downstream reader for the FIR filter output stream. Each cycle it can capture one signed filtered sample into a first-word-fall-through FIFO and hands samples to a consumer over a valid/ready handshake. It also keeps running statistics: sample count, peak magnitude and a sticky overflow flag. It honours the same `low_power_mode` signal as the filter, so no samples are captured while the filter's clock is blocked.

---
 rtl/fir_sample_reader_if.sv | 26 ++
 rtl/fir_sample_reader.sv | 102 ++++++++++
 tb/tb_fir_sample_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_reader_if.sv
// rtl/fir_sample_reader_if.sv - sample-in / sample-out handshake bundle for fir_sample_reader
interface fir_sample_reader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/fir_sample_reader.sv
// rtl/fir_sample_reader.sv - FWFT sample FIFO after the FIR with count/peak/overflow statistics
module fir_sample_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     low_power_mode,
    input  logic                     clear_stats,
    fir_sample_reader_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DATA_W-1:0]        peak_abs,
    output logic [15:0]              sample_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_VAL  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] abs_x;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_req;
    logic              accept;
    logic              drop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign pop      = bus.out_valid & bus.out_ready;
    assign push_req = bus.in_valid & ~low_power_mode;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign bus.out_valid = ~empty;
    // When empty, keep showing the last popped sample rather than a stale slot.
    assign bus.out_data  = empty ? last_data : mem[rd_ptr];

    always_comb begin
        abs_x = bus.in_data;
        if (bus.in_data[DATA_W-1]) begin
            abs_x = (bus.in_data == MIN_VAL) ? MAX_VAL : (~bus.in_data + DATA_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            last_data <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem[rd_ptr];
            end
            case ({accept, pop})
                2'b10:   level <= level + (PTR_W+1)'(1);
                2'b01:   level <= level - (PTR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow     <= 1'b0;
            peak_abs     <= '0;
            sample_count <= '0;
        end else if (clear_stats) begin
            // Statistics restart from a sample accepted in the clearing cycle.
            overflow     <= 1'b0;
            peak_abs     <= accept ? abs_x : '0;
            sample_count <= accept ? 16'd1 : 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                sample_count <= sample_count + 16'd1;
                if (abs_x > peak_abs) begin
                    peak_abs <= abs_x;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_sample_reader.sv
// tb/tb_fir_sample_reader.sv - scoreboard bench for fir_sample_reader
module tb_fir_sample_reader;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        low_power_mode = 1'b0;
    logic        clear_stats = 1'b0;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] peak_abs;
    logic [15:0] sample_count;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [$];

    fir_sample_reader_if #(.DATA_W(DATA_W)) bus ();

    fir_sample_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .low_power_mode (low_power_mode),
        .clear_stats    (clear_stats),
        .bus            (bus.slave),
        .level          (level),
        .overflow       (overflow),
        .peak_abs       (peak_abs),
        .sample_count   (sample_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input bit expect_out);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (expect_out) exp_q.push_back(d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    // Scoreboard: every handshake seen between edges must match the next expected sample.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pop_unexpected: got %0h expected no output", bus.out_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        fails++;
                        $display("FAIL pop_data: got %0h expected %0h", bus.out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_peak", 32'(peak_abs), 0);
        check("rst_count", 32'(sample_count), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        tick();
        rst_n = 1'b1;

        // basic push then drain
        push(16'h1000, 1);
        check("basic_valid_after_first", 32'(bus.out_valid), 1);
        push(16'h2000, 1);
        push(16'h3000, 1);
        check("basic_level", 32'(level), 3);
        check("basic_head", 32'(bus.out_data), 32'h1000);
        check("basic_count", 32'(sample_count), 3);
        check("basic_peak", 32'(peak_abs), 32'h3000);
        drain(3);
        check("basic_empty_valid", 32'(bus.out_valid), 0);
        check("basic_empty_level", 32'(level), 0);
        check("basic_hold_data", 32'(bus.out_data), 32'h3000);

        // fill and overflow
        clear_pulse();
        check("clr_count", 32'(sample_count), 0);
        check("clr_peak", 32'(peak_abs), 0);
        for (int i = 1; i <= 10; i++) push(16'(i), i <= DEPTH);
        check("fill_level", 32'(level), 8);
        check("fill_overflow", 32'(overflow), 1);
        check("fill_count", 32'(sample_count), 8);
        check("fill_peak", 32'(peak_abs), 8);
        bus.out_ready = 1'b1;
        push(16'd11, 1);
        bus.out_ready = 1'b0;
        check("full_pushpop_level", 32'(level), 8);
        check("full_pushpop_count", 32'(sample_count), 9);
        check("full_pushpop_peak", 32'(peak_abs), 11);
        clear_stats = 1'b1;
        push(16'd99, 0);
        clear_stats = 1'b0;
        check("clr_drop_overflow", 32'(overflow), 0);
        check("clr_drop_count", 32'(sample_count), 0);
        check("clr_drop_peak", 32'(peak_abs), 0);
        check("clr_drop_level", 32'(level), 8);
        drain(8);
        check("fill_drained", 32'(level), 0);

        // low-power gating while draining
        push(16'h0011, 1);
        push(16'h0022, 1);
        low_power_mode = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 16'h7FFF;
        bus.out_ready  = 1'b1;
        tick();
        check("lpm_level_1", 32'(level), 1);
        for (int i = 0; i < 4; i++) tick();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        low_power_mode = 1'b0;
        check("lpm_level_0", 32'(level), 0);
        check("lpm_count", 32'(sample_count), 2);
        check("lpm_peak", 32'(peak_abs), 32'h22);

        // peak tracking and saturation
        clear_pulse();
        push(16'hFFFB, 1);
        check("peak_m5", 32'(peak_abs), 5);
        push(16'd300, 1);
        check("peak_300", 32'(peak_abs), 300);
        push(16'h8000, 1);
        check("peak_sat", 32'(peak_abs), 32'h7FFF);
        clear_stats = 1'b1;
        push(16'hFFF9, 1);
        clear_stats = 1'b0;
        check("clr_acc_peak", 32'(peak_abs), 7);
        check("clr_acc_count", 32'(sample_count), 1);
        check("clr_acc_overflow", 32'(overflow), 0);
        check("clr_acc_level", 32'(level), 4);
        drain(4);

        // concurrent push/pop with pointer wrap
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_data = 16'(16'h0100 + i);
            exp_q.push_back(bus.in_data);
            tick();
            check("wrap_level", 32'(level), 1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("wrap_level_end", 32'(level), 0);

        // sample_count wrap past 0xFFFF
        bus.in_valid = 1'b1;
        clear_stats  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.in_data = 16'(i);
            exp_q.push_back(bus.in_data);
            tick();
            clear_stats = 1'b0;
            if (i == 0)     check("cnt_restart", 32'(sample_count), 1);
            if (i == 65534) check("cnt_max", 32'(sample_count), 32'hFFFF);
        end
        bus.in_valid = 1'b0;
        check("cnt_wrap", 32'(sample_count), 0);
        check("cnt_peak", 32'(peak_abs), 32'h7FFF);
        tick();
        bus.out_ready = 1'b0;
        check("cnt_drained", 32'(level), 0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) push(16'(16'hA0 + i), 1);
        check("arst_pre_level", 32'(level), 5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_level", 32'(level), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_peak", 32'(peak_abs), 0);
        check("arst_count", 32'(sample_count), 0);
        check("arst_data", 32'(bus.out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_post_valid", 32'(bus.out_valid), 0);
        push(16'h0042, 1);
        check("arst_push_data", 32'(bus.out_data), 32'h42);
        check("arst_push_level", 32'(level), 1);
        check("arst_push_valid", 32'(bus.out_valid), 1);
        drain(1);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
